card_dealer: RTL and testbench

Deals a hand of unique playing cards into a player's card bank by drawing random candidates from a free-running LFSR and rejecting cards already dealt from the current deck. It sits directly upstream of the player card bank and drives that bank's single-register write port (enable, 3-bit select, 8-bit data), one card per write. It tracks the 52-card deck across hands and refuses to deal when too few cards remain.

---
 rtl/card_dealer_if.sv | 25 ++
 rtl/card_dealer.sv | 152 +++++++++++++++
 tb/tb_card_dealer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/card_dealer_if.sv
// Bus between the card dealer and its controller / player card bank:
// the hand-request controls plus the bank's single-register write port and status.
interface card_dealer_if;
    logic        start;
    logic        deck_clear;
    logic        seed_load;
    logic [15:0] seed;
    logic        wr_en;
    logic [2:0]  wr_sel;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [5:0]  cards_left;

    modport master (
        output start, deck_clear, seed_load, seed,
        input  wr_en, wr_sel, wr_data, busy, done, error, cards_left
    );

    modport slave (
        input  start, deck_clear, seed_load, seed,
        output wr_en, wr_sel, wr_data, busy, done, error, cards_left
    );
endinterface

// File: rtl/card_dealer.sv
// Deals N_CARDS unique cards per hand from a 52-card deck into the player card bank,
// drawing candidates from a free-running 16-bit LFSR and rejecting dealt cards.
module card_dealer #(
    parameter int          N_CARDS      = 5,
    parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
    input  logic         clk,
    input  logic         reset,
    card_dealer_if.slave bus
);

    localparam logic [5:0] DECK_SIZE = 6'd52;
    localparam logic [5:0] HAND_SIZE = 6'(N_CARDS);
    localparam logic [2:0] LAST_SLOT = 3'(N_CARDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAW  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [15:0] lfsr;
    logic [51:0] used_mask;
    logic [5:0]  cards_left_q;
    logic [2:0]  slot;

    logic [5:0]  cand;
    logic [5:0]  cand_idx;
    logic        cand_rank_ok;
    logic        cand_ok;

    logic        take_card;
    logic        refuse;
    logic        clear_now;
    logic [5:0]  avail;

    function automatic logic rank_is_valid(input logic [5:0] code);
        return (code[3:0] >= 4'd1) && (code[3:0] <= 4'd13);
    endfunction

    // Deck position suit*13 + rank-1; only meaningful for a valid rank.
    function automatic logic [5:0] deck_index(input logic [5:0] code);
        return ({4'b0000, code[5:4]} * 6'd13) + {2'b00, code[3:0]} - 6'd1;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    assign cand         = lfsr[5:0];
    assign cand_rank_ok = rank_is_valid(cand);
    assign cand_idx     = cand_rank_ok ? deck_index(cand) : 6'd0;
    assign cand_ok      = cand_rank_ok && !used_mask[cand_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        take_card = 1'b0;
        refuse    = 1'b0;
        clear_now = 1'b0;
        avail     = cards_left_q;
        case (state)
            IDLE: begin
                // A simultaneous clear is applied before start is judged.
                clear_now = bus.deck_clear;
                avail     = bus.deck_clear ? DECK_SIZE : cards_left_q;
                if (bus.start) begin
                    if (avail >= HAND_SIZE) begin
                        state_nxt = DRAW;
                    end else begin
                        refuse = 1'b1;
                    end
                end
            end
            DRAW: begin
                if (cand_ok) begin
                    take_card = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                state_nxt = (slot == LAST_SLOT) ? DONE : DRAW;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr             <= SEED_DEFAULT;
            used_mask        <= '0;
            cards_left_q     <= DECK_SIZE;
            slot             <= 3'd0;
            bus.wr_en        <= 1'b0;
            bus.wr_sel       <= 3'd0;
            bus.wr_data      <= 8'd0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.error        <= 1'b0;
        end else begin
            if (bus.seed_load) begin
                lfsr <= (bus.seed == 16'd0) ? SEED_DEFAULT : bus.seed;
            end else begin
                lfsr <= lfsr_step(lfsr);
            end

            if (clear_now) begin
                used_mask    <= '0;
                cards_left_q <= DECK_SIZE;
            end else if (take_card) begin
                used_mask[cand_idx] <= 1'b1;
                cards_left_q        <= cards_left_q - 6'd1;
            end

            if (state == IDLE && state_nxt == DRAW) begin
                slot <= 3'd0;
            end else if (state == WRITE) begin
                slot <= slot + 3'd1;
            end

            // Write address/data change only together with the write strobe.
            if (take_card) begin
                bus.wr_sel  <= slot;
                bus.wr_data <= {2'b00, cand};
            end

            bus.wr_en <= take_card;
            bus.busy  <= (state_nxt != IDLE);
            bus.done  <= (state_nxt == DONE);
            bus.error <= refuse;
        end
    end

    assign bus.cards_left = cards_left_q;

endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer: stimulus tasks predict each hand's writes,
// done and error pulses (with cycle stamps); a negedge monitor pops and compares.
module tb_card_dealer;

    localparam int EV_WR   = 0;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;
    localparam int HAND_BUDGET = 20000;

    typedef struct {
        int         kind;
        logic [2:0] sel;
        logic [7:0] data;
        int         cyc;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    card_dealer_if bus ();

    card_dealer #(
        .N_CARDS     (5),
        .SEED_DEFAULT(16'hACE1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    ev_t        exp_q[$];
    logic [7:0] seq[$];
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_wr   = 0;
    int n_done = 0;
    int n_err  = 0;
    logic prev_wr = 1'b0;

    logic [15:0] m_lfsr;
    bit          m_used[64];
    int          m_left;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

    always @(posedge clk) begin
        if (reset)              m_lfsr <= 16'hACE1;
        else if (bus.seed_load) m_lfsr <= (bus.seed == 16'd0) ? 16'hACE1 : bus.seed;
        else                    m_lfsr <= step(m_lfsr);
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int distinct(input logic [7:0] s[$]);
        bit seen[256];
        int n = 0;
        foreach (s[i]) begin
            if (!seen[s[i]]) begin
                seen[s[i]] = 1'b1;
                n++;
            end
        end
        return n;
    endfunction

    task automatic model_clear();
        foreach (m_used[i]) m_used[i] = 1'b0;
        m_left = 52;
    endtask

    // Walk the model LFSR from the first DRAW cycle (which starts at edge t).
    task automatic predict_hand(input int t);
        logic [15:0] x;
        logic [5:0]  code;
        int d;
        int r;
        ev_t e;
        x = m_lfsr;
        d = t;
        for (int s = 0; s < 5; s++) begin
            r = 0;
            forever begin
                code = x[5:0];
                if (code[3:0] >= 4'd1 && code[3:0] <= 4'd13 && !m_used[code]) break;
                x = step(x);
                r++;
                if (r > 70000) begin
                    $display("FAIL predict_hand: no valid candidate found");
                    $fatal(1);
                end
            end
            m_used[code] = 1'b1;
            m_left--;
            e.kind = EV_WR; e.sel = 3'(s); e.data = {2'b00, code}; e.cyc = d + r + 1;
            exp_q.push_back(e);
            x = step(step(x));
            d = d + r + 2;
        end
        e.kind = EV_DONE; e.sel = 3'd0; e.data = 8'd0; e.cyc = d;
        exp_q.push_back(e);
    endtask

    task automatic deal(input logic clr);
        ev_t e;
        int t;
        bus.start      = 1'b1;
        bus.deck_clear = clr;
        @(posedge clk);
        #1;
        bus.start      = 1'b0;
        bus.deck_clear = 1'b0;
        t = cyc;
        if (clr) model_clear();
        if (m_left >= 5) begin
            predict_hand(t);
        end else begin
            e.kind = EV_ERR; e.sel = 3'd0; e.data = 8'd0; e.cyc = t;
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((exp_q.size() != 0 || bus.busy) && k < HAND_BUDGET) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (k >= HAND_BUDGET) begin
            check("hand_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic seed_clear(input logic [15:0] s);
        bus.seed_load  = 1'b1;
        bus.seed       = s;
        bus.deck_clear = 1'b1;
        @(posedge clk);
        #1;
        bus.seed_load  = 1'b0;
        bus.deck_clear = 1'b0;
        model_clear();
    endtask

    always @(negedge clk) begin
        ev_t e;
        int  kind;
        if (bus.wr_en || bus.done || bus.error) begin
            kind = bus.wr_en ? EV_WR : (bus.done ? EV_DONE : EV_ERR);
            if (exp_q.size() == 0) begin
                check("unexpected_output_kind", kind, -1);
            end else begin
                e = exp_q.pop_front();
                check("event_kind", kind, e.kind);
                check("event_cycle", cyc, e.cyc);
                if (e.kind == EV_WR) begin
                    check("wr_sel", bus.wr_sel, e.sel);
                    check("wr_data", bus.wr_data, e.data);
                end
            end
            if (bus.wr_en) begin
                check("wr_en_gap", prev_wr, 0);
                check("busy_during_write", bus.busy, 1);
                n_wr++;
                seq.push_back(bus.wr_data);
            end
            if (bus.done)  n_done++;
            if (bus.error) n_err++;
        end
        prev_wr = bus.wr_en;
    end

    initial begin
        logic [7:0] seq_a[$];
        int w0;
        int cl0;
        int k;

        bus.start = 1'b0; bus.deck_clear = 1'b0; bus.seed_load = 1'b0; bus.seed = 16'd0;
        reset = 1'b1;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_wr_en", bus.wr_en, 0);
        check("rst_wr_sel", bus.wr_sel, 0);
        check("rst_wr_data", bus.wr_data, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_error", bus.error, 0);
        check("rst_cards_left", bus.cards_left, 52);
        repeat (20) @(posedge clk);
        #1;
        check("idle_wr_count", n_wr, 0);

        // First hand with seed 1234, then nine more from the same deck.
        bus.seed_load = 1'b1; bus.seed = 16'h1234;
        @(posedge clk);
        #1;
        bus.seed_load = 1'b0;
        seq.delete();
        deal(1'b0);
        wait_idle();
        check("hand1_cards_left", bus.cards_left, 47);
        check("hand1_writes", n_wr, 5);
        check("hand1_done", n_done, 1);
        for (int h = 0; h < 9; h++) begin
            deal(1'b0);
            wait_idle();
        end
        check("ten_hands_cards_left", bus.cards_left, 2);
        check("ten_hands_distinct", distinct(seq), 50);
        check("ten_hands_writes", seq.size(), 50);

        // Too few cards: refused start.
        w0 = n_wr;
        deal(1'b0);
        check("refused_busy", bus.busy, 0);
        wait_idle();
        check("refused_no_write", n_wr, w0);
        check("refused_error_count", n_err, 1);
        check("refused_cards_left", bus.cards_left, 2);

        // Clear together with start is judged against a full deck.
        deal(1'b1);
        wait_idle();
        check("clear_start_cards_left", bus.cards_left, 47);

        // Seed 0 and seed ACE1 must deal the same hand; so must two equal seeds.
        seed_clear(16'h0000);
        seq.delete();
        deal(1'b0);
        wait_idle();
        seq_a = seq;
        seed_clear(16'hACE1);
        seq.delete();
        deal(1'b0);
        wait_idle();
        check("det_len_zero_seed", seq.size(), 5);
        for (int i = 0; i < 5 && i < seq.size() && i < seq_a.size(); i++)
            check("det_zero_vs_default", seq[i], seq_a[i]);
        seed_clear(16'h5A5A);
        seq.delete();
        deal(1'b0);
        wait_idle();
        seq_a = seq;
        seed_clear(16'h5A5A);
        seq.delete();
        deal(1'b0);
        wait_idle();
        check("det_len_same_seed", seq.size(), 5);
        for (int i = 0; i < 5 && i < seq.size() && i < seq_a.size(); i++)
            check("det_same_seed", seq[i], seq_a[i]);

        // start and deck_clear while busy are ignored.
        cl0 = bus.cards_left;
        w0  = n_wr;
        deal(1'b0);
        @(posedge clk);
        #1;
        bus.start = 1'b1; bus.deck_clear = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.start = 1'b0; bus.deck_clear = 1'b0;
        wait_idle();
        check("busy_ignore_writes", n_wr - w0, 5);
        check("busy_ignore_cards_left", bus.cards_left, cl0 - 5);

        // Reset on the third write of a hand.
        w0 = n_wr;
        deal(1'b0);
        k = 0;
        while (n_wr < w0 + 3 && k < HAND_BUDGET) begin
            @(negedge clk);
            #1;
            k++;
        end
        check("reach_third_write", n_wr - w0, 3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        model_clear();
        check("midrst_busy", bus.busy, 0);
        check("midrst_wr_en", bus.wr_en, 0);
        check("midrst_cards_left", bus.cards_left, 52);
        w0 = n_wr;
        deal(1'b0);
        wait_idle();
        check("after_rst_writes", n_wr - w0, 5);
        check("after_rst_cards_left", bus.cards_left, 47);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
